// File: rtl/pattern_scheduler.sv
// Chooses the active test pattern and commits changes only on frame boundaries
// (falling edge of vsync). Supports manual stepping, auto-cycling, freeze and a sync watchdog.
module pattern_scheduler #(
  parameter int          PATTERN_NUM = 8,
  parameter int          PAT_W       = 4,
  parameter int          HOLD_FRAMES = 60,
  parameter logic [21:0] TIMEOUT     = 22'd4000000
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             ivsync,
  input  logic             ide,
  input  logic             inext,
  input  logic             iprev,
  input  logic             iauto_en,
  input  logic             ifreeze,
  output logic [PAT_W-1:0] opattern_id,
  output logic             ochange,
  output logic [7:0]       oframe_cnt,
  output logic             osync_ok,
  output logic             ode_err
);

  typedef enum logic [1:0] {SYNC = 2'd0, RUN = 2'd1, FREEZE = 2'd2} state_t;

  localparam logic [PAT_W-1:0] LAST_ID   = PAT_W'(PATTERN_NUM - 1);
  localparam logic [31:0]      HOLD_LAST = 32'(HOLD_FRAMES - 1);

  state_t           state_reg, state_next;
  logic             vs_d_reg;
  logic [PAT_W-1:0] id_reg, id_next;
  logic             change_reg, change_next;
  logic [7:0]       cnt_reg, cnt_next;
  logic             de_err_reg, de_err_next;
  logic             nxt_flag_reg, nxt_flag_next;
  logic             prv_flag_reg, prv_flag_next;
  logic [21:0]      wd_reg, wd_next;

  logic             fb;
  logic [PAT_W-1:0] id_inc, id_dec;
  logic [7:0]       cnt_inc;
  logic             wd_expired;

  assign fb         = vs_d_reg & ~ivsync;
  assign id_inc     = (id_reg == LAST_ID) ? '0 : id_reg + 1'b1;
  assign id_dec     = (id_reg == '0) ? LAST_ID : id_reg - 1'b1;
  assign cnt_inc    = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
  assign wd_expired = (wd_reg == TIMEOUT - 22'd1);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_reg    <= SYNC;
      vs_d_reg     <= 1'b0;
      id_reg       <= '0;
      change_reg   <= 1'b0;
      cnt_reg      <= 8'd0;
      de_err_reg   <= 1'b0;
      nxt_flag_reg <= 1'b0;
      prv_flag_reg <= 1'b0;
      wd_reg       <= 22'd0;
    end else begin
      state_reg    <= state_next;
      vs_d_reg     <= ivsync;
      id_reg       <= id_next;
      change_reg   <= change_next;
      cnt_reg      <= cnt_next;
      de_err_reg   <= de_err_next;
      nxt_flag_reg <= nxt_flag_next;
      prv_flag_reg <= prv_flag_next;
      wd_reg       <= wd_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    change_next = 1'b0;
    cnt_next    = cnt_reg;
    de_err_next = de_err_reg | (fb & ide);
    wd_next     = (fb || wd_expired) ? 22'd0 : wd_reg + 22'd1;
    // A press coincident with a boundary is kept for the following frame.
    nxt_flag_next = fb ? inext : (nxt_flag_reg | inext);
    prv_flag_next = fb ? iprev : (prv_flag_reg | iprev);

    case (state_reg)
      SYNC: begin
        if (fb) state_next = RUN;
      end
      RUN: begin
        if (fb) begin
          if (nxt_flag_reg ^ prv_flag_reg) begin
            id_next     = nxt_flag_reg ? id_inc : id_dec;
            cnt_next    = 8'd0;
            change_next = 1'b1;
          end else if (iauto_en && (32'(cnt_reg) == HOLD_LAST)) begin
            id_next     = id_inc;
            cnt_next    = 8'd0;
            change_next = 1'b1;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        if (ifreeze) state_next = FREEZE;
        if (!fb && wd_expired) state_next = SYNC;
      end
      FREEZE: begin
        nxt_flag_next = 1'b0;
        prv_flag_next = 1'b0;
        if (fb) cnt_next = cnt_inc;
        if (!ifreeze) state_next = RUN;
        if (!fb && wd_expired) state_next = SYNC;
      end
      default: state_next = SYNC;
    endcase
  end

  assign opattern_id = id_reg;
  assign ochange     = change_reg;
  assign oframe_cnt  = cnt_reg;
  assign osync_ok    = (state_reg != SYNC);
  assign ode_err     = de_err_reg;

endmodule
